// File: rtl/jk_counter_ctrl_if.sv
// Command handshake and status bundle for the JK-bank up/down counter sequencer.
// The bench or host drives the master side; the sequencer is the slave.
interface jk_counter_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_steps;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_steps,
    input  cmd_ready, count, busy, done, wrap
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_steps,
    output cmd_ready, count, busy, done, wrap
  );
endinterface

// File: rtl/jk_counter_ctrl.sv
// Sequencer driving a bank of JK flip-flops as a loadable modulo-2^WIDTH up/down counter.
// Commands CLEAR/LOAD/UP n/DOWN n arrive on a valid/ready handshake; done and wrap are pulses.
module jk_counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  jk_counter_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {INIT, IDLE, RUN, DONE} state_e;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] bank_q, bank_d;
  logic [WIDTH-1:0] j_s, k_s, tog_s;
  logic             accept_s;

  // Ripple toggle mask: a bit flips when every lower bit is 1 (up) or 0 (down)
  always_comb begin
    logic carry_s;
    carry_s = 1'b1;
    tog_s   = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      tog_s[i] = carry_s;
      if (op_q == OP_UP) begin
        carry_s = carry_s & bank_q[i];
      end else begin
        carry_s = carry_s & ~bank_q[i];
      end
    end
  end

  // FSM next state, command capture and per-cell JK drive
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    rem_d    = rem_q;
    wrap_d   = 1'b0;
    j_s      = {WIDTH{1'b0}};
    k_s      = {WIDTH{1'b0}};
    accept_s = bus.cmd_valid && ready_q;
    case (state_q)
      INIT: begin
        k_s     = {WIDTH{1'b1}};
        state_d = IDLE;
      end
      IDLE: begin
        if (accept_s) begin
          op_d   = bus.cmd_op;
          data_d = bus.cmd_data;
          rem_d  = bus.cmd_steps;
          if (bus.cmd_op[1] && (bus.cmd_steps == {CNT_W{1'b0}})) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        case (op_q)
          OP_CLEAR: begin
            k_s     = {WIDTH{1'b1}};
            state_d = DONE;
          end
          OP_LOAD: begin
            j_s     = data_q;
            k_s     = ~data_q;
            state_d = DONE;
          end
          default: begin
            j_s    = tog_s;
            k_s    = tog_s;
            wrap_d = (op_q == OP_UP) ? (&bank_q) : (~|bank_q);
            if (rem_q != {CNT_W{1'b0}}) begin
              rem_d = rem_q - CNT_W'(1);
            end else begin
              rem_d = rem_q;
            end
            // rem_q is never 0 here for a real step command; treat it as last step
            if (rem_q <= CNT_W'(1)) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end
        endcase
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // JK cell behaviour for every bit of the bank
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j_s[i], k_s[i]})
        2'b01:   bank_d[i] = 1'b0;
        2'b10:   bank_d[i] = 1'b1;
        2'b11:   bank_d[i] = ~bank_q[i];
        default: bank_d[i] = bank_q[i];
      endcase
    end
  end

  // The bank has no reset pin; reset forces INIT, which drives clear into every cell
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  // FSM, command registers and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      op_q    <= OP_CLEAR;
      data_q  <= {WIDTH{1'b0}};
      rem_q   <= {CNT_W{1'b0}};
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;
  assign bus.count     = bank_q;

endmodule
